// File: rtl/kyber_xof_sampler_pkg.sv
// Shared constants and types for the Kyber XOF rejection sampler.
package kyber_xof_sampler_pkg;

  localparam int BW_DATA  = 64;
  localparam int BW_IBLEN = 16;
  localparam int BW_OBLEN = 16;

  localparam logic [8:0]          P_N         = 9'd256;
  localparam logic [11:0]         P_Q         = 12'd3329;
  localparam logic [BW_OBLEN-1:0] P_OBYTES    = 16'd672;
  localparam logic [BW_IBLEN-1:0] XOF_MSG_LEN = 16'd34;
  localparam logic [1:0]          MODE_SHAKE128 = 2'b00;

  localparam logic [2:0] LAST_MSG_WORD = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_SAMPLE,
    S_DRAIN,
    S_DONE
  } state_t;

endpackage

// File: rtl/kyber_xof_sampler_rej_lane.sv
// One byte triple -> two 12-bit candidates and their accept flags.
module kyber_rej_lane
  import kyber_xof_sampler_pkg::*;
(
  input  logic [7:0]  i_b0,
  input  logic [7:0]  i_b1,
  input  logic [7:0]  i_b2,
  output logic [11:0] o_d1,
  output logic [11:0] o_d2,
  output logic        o_acc1,
  output logic        o_acc2
);

  assign o_d1   = {i_b1[3:0], i_b0};
  assign o_d2   = {i_b2, i_b1[7:4]};
  assign o_acc1 = (o_d1 < P_Q);
  assign o_acc2 = (o_d2 < P_Q);

endmodule

// File: rtl/kyber_xof_sampler.sv
// Kyber matrix-A sampler: sends seed||x||y to keccak (SHAKE128), then
// rejection-samples the squeezed stream into a compacted coefficient bus.
//
// state    | meaning
// S_IDLE   | waiting for i_start
// S_SEND   | presenting the five 64-bit message words
// S_SAMPLE | parsing squeezed words into coefficients
// S_DRAIN  | P_N reached; discarding words until keccak completes
// S_DONE   | one-cycle completion pulse
module kyber_xof_sampler
  import kyber_xof_sampler_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_start,
  input  logic [255:0]        i_seed,
  input  logic [7:0]          i_x,
  input  logic [7:0]          i_y,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err,
  output logic [71:0]         o_coef,
  output logic [2:0]          o_coef_cnt,
  output logic [7:0]          o_coef_base,
  output logic                o_coef_valid,
  output logic [1:0]          o_kc_mode,
  output logic [BW_DATA-1:0]  o_kc_ibytes,
  output logic                o_kc_ibytes_valid,
  input  logic                i_kc_ibytes_ready,
  output logic [BW_IBLEN-1:0] o_kc_ibytes_len,
  output logic [BW_OBLEN-1:0] o_kc_obytes_len,
  input  logic [BW_DATA-1:0]  i_kc_obytes,
  input  logic                i_kc_obytes_valid,
  input  logic                i_kc_obytes_done
);

  state_t      r_state, w_state_next;
  logic [2:0]  r_widx;
  logic [7:0]  r_res0, r_res1;
  logic [1:0]  r_res_cnt;
  logic [8:0]  r_count;
  logic [71:0] r_coef;
  logic [2:0]  r_coef_cnt;
  logic [7:0]  r_coef_base;

  logic        w_start_acc, w_take;
  logic [7:0]  w_bytes [10];
  logic [11:0] w_cand [6];
  logic [5:0]  w_acc_raw, w_acc;
  logic [11:0] w_lane [6];
  logic [71:0] w_coef_flat;
  logic [2:0]  w_n;
  logic [8:0]  w_room, w_count_next;

  assign w_start_acc  = (r_state == S_IDLE) && i_start;
  assign w_take       = (r_state == S_SAMPLE) && i_kc_obytes_valid;
  assign w_room       = P_N - r_count;
  assign w_count_next = w_take ? (r_count + {6'd0, w_n}) : r_count;

  // Align residue bytes in front of the new word: byte 0 is oldest in stream order.
  always_comb begin
    for (int i = 0; i < 10; i++) w_bytes[i] = 8'd0;
    case (r_res_cnt)
      2'd1: begin
        w_bytes[0] = r_res0;
        for (int i = 0; i < 8; i++) w_bytes[i+1] = i_kc_obytes[63-8*i -: 8];
      end
      2'd2: begin
        w_bytes[0] = r_res0;
        w_bytes[1] = r_res1;
        for (int i = 0; i < 8; i++) w_bytes[i+2] = i_kc_obytes[63-8*i -: 8];
      end
      default: begin
        for (int i = 0; i < 8; i++) w_bytes[i] = i_kc_obytes[63-8*i -: 8];
      end
    endcase
  end

  for (genvar t = 0; t < 3; t++) begin : g_lane
    kyber_rej_lane u_lane (
      .i_b0   (w_bytes[3*t]),
      .i_b1   (w_bytes[3*t+1]),
      .i_b2   (w_bytes[3*t+2]),
      .o_d1   (w_cand[2*t]),
      .o_d2   (w_cand[2*t+1]),
      .o_acc1 (w_acc_raw[2*t]),
      .o_acc2 (w_acc_raw[2*t+1])
    );
  end

  // With no residue only 8 bytes are present, so the third triple is not real.
  assign w_acc = w_acc_raw & ((r_res_cnt == 2'd0) ? 6'b001111 : 6'b111111);

  // Compact accepted candidates into low lanes, stopping once P_N would be exceeded.
  always_comb begin
    for (int k = 0; k < 6; k++) w_lane[k] = 12'd0;
    w_n = 3'd0;
    for (int k = 0; k < 6; k++) begin
      if (w_acc[k] && ({6'd0, w_n} < w_room)) begin
        w_lane[w_n] = w_cand[k];
        w_n         = w_n + 3'd1;
      end
    end
    w_coef_flat = '0;
    for (int k = 0; k < 6; k++) w_coef_flat[12*k +: 12] = w_lane[k];
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_state_next = S_SEND;
      S_SEND:   if (i_kc_ibytes_ready && (r_widx == LAST_MSG_WORD)) w_state_next = S_SAMPLE;
      S_SAMPLE: begin
        if (i_kc_obytes_done)          w_state_next = S_DONE;
        else if (w_count_next == P_N)  w_state_next = S_DRAIN;
      end
      S_DRAIN:  if (i_kc_obytes_done) w_state_next = S_DONE;
      S_DONE:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // Message word index, advanced on each accepted word.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)                                     r_widx <= 3'd0;
    else if (w_start_acc)                            r_widx <= 3'd0;
    else if ((r_state == S_SEND) && i_kc_ibytes_ready) r_widx <= r_widx + 3'd1;
  end

  // Residue, coefficient count and registered coefficient bus.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_res0      <= 8'd0;
      r_res1      <= 8'd0;
      r_res_cnt   <= 2'd0;
      r_count     <= 9'd0;
      r_coef      <= '0;
      r_coef_cnt  <= 3'd0;
      r_coef_base <= 8'd0;
    end else begin
      r_coef      <= '0;
      r_coef_cnt  <= 3'd0;
      r_coef_base <= 8'd0;
      if (w_start_acc) begin
        r_res0    <= 8'd0;
        r_res1    <= 8'd0;
        r_res_cnt <= 2'd0;
        r_count   <= 9'd0;
      end else if (w_take) begin
        r_count <= w_count_next;
        case (r_res_cnt)
          2'd0: begin
            r_res0    <= w_bytes[6];
            r_res1    <= w_bytes[7];
            r_res_cnt <= 2'd2;
          end
          2'd2: begin
            r_res0    <= w_bytes[9];
            r_res_cnt <= 2'd1;
          end
          default: r_res_cnt <= 2'd0;
        endcase
        if (w_n != 3'd0) begin
          r_coef      <= w_coef_flat;
          r_coef_cnt  <= w_n;
          r_coef_base <= r_count[7:0];
        end
      end
    end
  end

  // Message word mux; W4 carries x, y and zero padding.
  always_comb begin
    o_kc_ibytes = '0;
    if (r_state == S_SEND) begin
      case (r_widx)
        3'd0:    o_kc_ibytes = i_seed[255:192];
        3'd1:    o_kc_ibytes = i_seed[191:128];
        3'd2:    o_kc_ibytes = i_seed[127:64];
        3'd3:    o_kc_ibytes = i_seed[63:0];
        3'd4:    o_kc_ibytes = {i_x, i_y, 48'h0};
        default: o_kc_ibytes = '0;
      endcase
    end
  end

  assign o_kc_ibytes_valid = (r_state == S_SEND);
  assign o_busy            = (r_state != S_IDLE);
  assign o_done            = (r_state == S_DONE);
  assign o_err             = (r_state == S_DONE) && (r_count < P_N);
  assign o_coef            = r_coef;
  assign o_coef_cnt        = r_coef_cnt;
  assign o_coef_base       = r_coef_base;
  assign o_coef_valid      = (r_coef_cnt != 3'd0);
  assign o_kc_mode         = MODE_SHAKE128;
  assign o_kc_ibytes_len   = XOF_MSG_LEN;
  assign o_kc_obytes_len   = P_OBYTES;

endmodule

// File: tb/tb_kyber_xof_sampler.sv
// Bench for kyber_xof_sampler: keccak stub, byte-queue reference model,
// per-cycle compare, and literal checks on hand-worked vectors.
module tb_kyber_xof_sampler;

  logic         i_clk = 1'b0;
  logic         i_rstn = 1'b0;
  logic         i_start = 1'b0;
  logic [255:0] i_seed = '0;
  logic [7:0]   i_x = '0, i_y = '0;
  logic         o_busy, o_done, o_err;
  logic [71:0]  o_coef;
  logic [2:0]   o_coef_cnt;
  logic [7:0]   o_coef_base;
  logic         o_coef_valid;
  logic [1:0]   o_kc_mode;
  logic [63:0]  o_kc_ibytes;
  logic         o_kc_ibytes_valid;
  logic         i_kc_ibytes_ready = 1'b1;
  logic [15:0]  o_kc_ibytes_len, o_kc_obytes_len;
  logic [63:0]  i_kc_obytes = '0;
  logic         i_kc_obytes_valid = 1'b0;
  logic         i_kc_obytes_done = 1'b0;

  kyber_xof_sampler dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_seed(i_seed),
    .i_x(i_x), .i_y(i_y), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_coef(o_coef), .o_coef_cnt(o_coef_cnt), .o_coef_base(o_coef_base),
    .o_coef_valid(o_coef_valid), .o_kc_mode(o_kc_mode),
    .o_kc_ibytes(o_kc_ibytes), .o_kc_ibytes_valid(o_kc_ibytes_valid),
    .i_kc_ibytes_ready(i_kc_ibytes_ready), .o_kc_ibytes_len(o_kc_ibytes_len),
    .o_kc_obytes_len(o_kc_obytes_len), .i_kc_obytes(i_kc_obytes),
    .i_kc_obytes_valid(i_kc_obytes_valid), .i_kc_obytes_done(i_kc_obytes_done)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state: bytes not yet consumed, coefficients produced so far.
  byte unsigned m_q[$];
  int  m_cnt = 0;
  int  m_sent = 0;
  bit  m_busy = 0, m_fin = 0;
  int  e_cnt = 0, e_base = 0;
  int  e_lane [6];
  bit  e_done = 0, e_err = 0, e_busy = 0;

  typedef struct { int cnt; int base; int l0; int l1; } ent_t;
  ent_t        log_q[$];
  logic [63:0] w4_seen = '0;
  logic        last_err = 1'b0;
  logic [63:0] words[$];

  function automatic logic [63:0] msg_word(input int w);
    byte unsigned msg [40];
    logic [63:0]  r;
    for (int i = 0; i < 40; i++) msg[i] = 8'd0;
    for (int i = 0; i < 32; i++) msg[i] = i_seed[255-8*i -: 8];
    msg[32] = i_x;
    msg[33] = i_y;
    r = '0;
    for (int b = 0; b < 8; b++) r = {r[55:0], msg[8*w+b]};
    return r;
  endfunction

  // Model: advances on each clock edge from the bench-driven inputs only.
  initial begin
    int n, d1, d2;
    byte unsigned b0, b1, b2;
    forever begin
      @(posedge i_clk or negedge i_rstn);
      e_cnt = 0; e_base = 0; e_done = 0; e_err = 0;
      for (int k = 0; k < 6; k++) e_lane[k] = 0;
      if (!i_rstn) begin
        m_busy = 0; m_fin = 0; m_sent = 0; m_cnt = 0; m_q.delete();
      end else if (m_fin) begin
        m_busy = 0; m_fin = 0;
      end else if (!m_busy) begin
        if (i_start) begin
          m_busy = 1; m_cnt = 0; m_sent = 0; m_q.delete();
        end
      end else if (m_sent < 5) begin
        if (i_kc_ibytes_ready) m_sent++;
      end else begin
        if (i_kc_obytes_valid) begin
          for (int b = 0; b < 8; b++) m_q.push_back(i_kc_obytes[63-8*b -: 8]);
          n = 0;
          while (m_q.size() >= 3) begin
            b0 = m_q.pop_front(); b1 = m_q.pop_front(); b2 = m_q.pop_front();
            d1 = (int'(b1) % 16) * 256 + int'(b0);
            d2 = int'(b2) * 16 + int'(b1) / 16;
            if (d1 < 3329 && m_cnt + n < 256) begin e_lane[n] = d1; n++; end
            if (d2 < 3329 && m_cnt + n < 256) begin e_lane[n] = d2; n++; end
          end
          if (n != 0) begin
            e_cnt = n; e_base = m_cnt; m_cnt += n;
          end
        end
        if (i_kc_obytes_done) begin
          m_fin = 1; e_done = 1; e_err = (m_cnt < 256);
        end
      end
      e_busy = m_busy;
    end
  end

  // Compare DUT against the model every cycle, mid-cycle.
  initial begin
    bit exp_iv;
    forever begin
      @(negedge i_clk);
      chk("busy", o_busy, e_busy);
      chk("done", o_done, e_done);
      chk("err", o_err, e_err);
      chk("coef_cnt", o_coef_cnt, e_cnt);
      chk("coef_valid", o_coef_valid, e_cnt != 0);
      if (e_cnt != 0) begin
        chk("coef_base", o_coef_base, e_base);
        for (int k = 0; k < e_cnt; k++) chk("coef_lane", o_coef[12*k +: 12], e_lane[k]);
      end else begin
        chk("coef_idle", o_coef != '0, 0);
      end
      exp_iv = m_busy && !m_fin && (m_sent < 5);
      chk("ibytes_valid", o_kc_ibytes_valid, exp_iv);
      if (exp_iv) chk("ibytes_word", o_kc_ibytes, msg_word(m_sent));
      if (o_kc_ibytes_valid && m_sent == 4) w4_seen = o_kc_ibytes;
      if (o_coef_cnt != 0)
        log_q.push_back('{int'(o_coef_cnt), int'(o_coef_base), int'(o_coef[11:0]), int'(o_coef[23:12])});
    end
  end

  // done_mode: 0 none, 1 with last word, 2 one cycle after. abort_at >= 0 resets after that many words.
  task automatic run(input logic [255:0] seed, input logic [7:0] x, input logic [7:0] y,
                     input int stall, input int done_mode, input int abort_at);
    int sent, g, left;
    logic seen;
    log_q.delete();
    i_seed = seed; i_x = x; i_y = y;
    @(negedge i_clk); i_start = 1'b1;
    @(negedge i_clk); i_start = 1'b0;
    sent = 0; g = 0; left = stall;
    while (sent < 5 && g < 100) begin
      if (sent == 2 && left > 0) begin i_kc_ibytes_ready = 1'b0; left--; end
      else i_kc_ibytes_ready = 1'b1;
      if (o_kc_ibytes_valid && i_kc_ibytes_ready) sent++;
      g++;
      @(negedge i_clk);
    end
    i_kc_ibytes_ready = 1'b1;
    if (g >= 100) chk("send_timeout", sent, 5);
    for (int i = 0; i < words.size(); i++) begin
      if (abort_at >= 0 && i == abort_at) break;
      i_kc_obytes = words[i];
      i_kc_obytes_valid = 1'b1;
      i_kc_obytes_done = (done_mode == 1) && (i == words.size() - 1);
      @(negedge i_clk);
    end
    i_kc_obytes_valid = 1'b0; i_kc_obytes = '0; i_kc_obytes_done = 1'b0;
    if (abort_at >= 0) begin
      #2 i_rstn = 1'b0;
      repeat (3) @(negedge i_clk);
      i_rstn = 1'b1;
      @(negedge i_clk);
      return;
    end
    if (done_mode == 2) begin
      i_kc_obytes_done = 1'b1;
      @(negedge i_clk);
      i_kc_obytes_done = 1'b0;
    end
    seen = o_done; g = 0;
    while (!seen && g < 20) begin @(negedge i_clk); seen = o_done; g++; end
    chk("done_seen", seen, 1);
    last_err = o_err;
    @(negedge i_clk);
  endtask

  function automatic int last_end();
    if (log_q.size() == 0) return -1;
    return log_q[log_q.size()-1].base + log_q[log_q.size()-1].cnt;
  endfunction

  initial begin
    logic [255:0] seed_a, seed_b;
    seed_a = 256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;
    seed_b = 256'hDEADBEEF_01234567_89ABCDEF_FEDCBA98_76543210_0F1E2D3C_4B5A6978_C0FFEE11;

    repeat (3) @(negedge i_clk);
    chk("rst_mode", o_kc_mode, 0);
    chk("rst_ilen", o_kc_ibytes_len, 34);
    chk("rst_olen", o_kc_obytes_len, 672);
    chk("rst_busy", o_busy, 0);
    chk("rst_coef_valid", o_coef_valid, 0);
    i_rstn = 1'b1;
    @(negedge i_clk);

    // Stub words with stall on W2.
    words = '{64'h010000FFFFFF000D, 64'hD0FFFFFFFFFFFFFF};
    run(seed_a, 8'hA5, 8'h3C, 3, 2, -1);
    chk("t1_w4", w4_seen, 64'hA53C000000000000);
    chk("t1_nlog", log_q.size(), 2);
    if (log_q.size() >= 2) begin
      chk("t1_cnt0", log_q[0].cnt, 2);
      chk("t1_base0", log_q[0].base, 0);
      chk("t1_l00", log_q[0].l0, 1);
      chk("t1_l01", log_q[0].l1, 0);
      chk("t1_cnt1", log_q[1].cnt, 2);
      chk("t1_base1", log_q[1].base, 2);
      chk("t1_l10", log_q[1].l0, 3328);
      chk("t1_l11", log_q[1].l1, 3328);
    end
    chk("t1_err", last_err, 1);

    // 01 0D D0: 3329 rejected, 3328 accepted.
    words = '{64'h010DD0FFFFFFFFFF};
    run(seed_b, 8'h02, 8'h01, 0, 2, -1);
    chk("t2_nlog", log_q.size(), 1);
    if (log_q.size() >= 1) begin
      chk("t2_cnt", log_q[0].cnt, 1);
      chk("t2_lane", log_q[0].l0, 3328);
    end

    // All-zero stream of 84 words.
    words.delete();
    repeat (84) words.push_back(64'h0);
    run(seed_a, 8'h00, 8'h01, 0, 2, -1);
    chk("t3_nlog", log_q.size(), 48);
    chk("t3_end", last_end(), 256);
    chk("t3_err", last_err, 0);

    // All-0xFF stream: nothing accepted.
    words.delete();
    repeat (84) words.push_back(64'hFFFFFFFFFFFFFFFF);
    run(seed_b, 8'h01, 8'h00, 0, 2, -1);
    chk("t4_nlog", log_q.size(), 0);
    chk("t4_err", last_err, 1);

    // Done arrives with the word that reaches 256.
    words.delete();
    repeat (48) words.push_back(64'h0);
    run(seed_a, 8'h03, 8'h02, 0, 1, -1);
    chk("t5_end", last_end(), 256);
    chk("t5_err", last_err, 0);

    // Pseudo-random stream, clipping lands mid-word.
    words.delete();
    repeat (120) words.push_back({$urandom(), $urandom()});
    run(seed_b, 8'h05, 8'h07, 1, 2, -1);
    chk("t6_end", last_end(), 256);

    // Reset mid-SAMPLE, then a clean follow-up run.
    words.delete();
    repeat (84) words.push_back(64'h0);
    run(seed_a, 8'h00, 8'h01, 0, 2, 10);
    chk("t7_busy", o_busy, 0);
    chk("t7_coef_valid", o_coef_valid, 0);
    run(seed_a, 8'h00, 8'h01, 2, 2, -1);
    chk("t8_nlog", log_q.size(), 48);
    chk("t8_end", last_end(), 256);
    chk("t8_err", last_err, 0);

    repeat (2) @(negedge i_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
